tdc_window_sequencer: RTL

TDC_WINDOW_SEQUENCER -- requirements
Module: tdc_window_sequencer

---
 rtl/tdc_window_sequencer_pkg.sv | 27 ++
 rtl/tdc_window_sequencer_gate.sv | 28 ++
 rtl/tdc_window_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tdc_window_sequencer_pkg.sv
// Shared types and width helpers for the TDC window sequencer.
// State encoding plus the accumulator-width arithmetic used by the top.
package tdc_window_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_GATE,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Gate timer width; covers the full 1..255 window range.
    localparam int TIMER_W = 8;

    function automatic int clog2_int(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int acc_width(input int count_w, input int num_windows);
        return count_w + clog2_int(num_windows);
    endfunction

endpackage

// File: rtl/tdc_window_sequencer_gate.sv
// Loadable window down-counter; done is high while the count sits at zero.
// Loading WINDOW_CYCLES-1 in CLEAR yields exactly WINDOW_CYCLES enabled cycles.
module gate_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tdc_window_sequencer.sv
// Burst sequencer for a TDC pulse counter: clear / gate / capture per window,
// summing the window counts and handing the result off with a valid/ack handshake.
module tdc_window_sequencer
    import tdc_window_sequencer_pkg::*;
#(
    parameter int WINDOW_CYCLES = 16,
    parameter int NUM_WINDOWS   = 4,
    parameter int COUNT_W       = 7
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           start,
    input  logic                                           abort,
    input  logic [COUNT_W-1:0]                             count_in,
    input  logic                                           counter_full,
    output logic                                           cnt_en,
    output logic                                           cnt_clear,
    output logic                                           busy,
    output logic [acc_width(COUNT_W, NUM_WINDOWS)-1:0]     result,
    output logic [COUNT_W-1:0]                             result_avg,
    output logic                                           result_valid,
    input  logic                                           result_ack,
    output logic                                           overflow
);

    localparam int LOG2_NW = clog2_int(NUM_WINDOWS);
    localparam int ACC_W   = acc_width(COUNT_W, NUM_WINDOWS);
    localparam int IDX_W   = (LOG2_NW > 0) ? LOG2_NW : 1;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [IDX_W-1:0]   win_idx;
    logic               ovf_flag;
    logic               last_win;
    logic               timer_load;
    logic               timer_en;
    logic               timer_done;

    assign acc_next   = acc + ACC_W'(count_in);
    assign last_win   = (win_idx == IDX_W'(NUM_WINDOWS - 1));
    assign timer_load = (state == S_CLEAR);
    assign timer_en   = (state == S_GATE);

    gate_timer #(
        .W(TIMER_W)
    ) u_gate_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIMER_W'(WINDOW_CYCLES - 1)),
        .en       (timer_en),
        .done     (timer_done)
    );

    // result/result_avg/overflow only change on entry to DONE, so an aborted
    // burst leaves the previous burst's values visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt_en       <= 1'b0;
            cnt_clear    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            result       <= '0;
            result_avg   <= '0;
            acc          <= '0;
            win_idx      <= '0;
            ovf_flag     <= 1'b0;
        end else if (state != S_IDLE && abort) begin
            state        <= S_IDLE;
            cnt_en       <= 1'b0;
            cnt_clear    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state     <= S_CLEAR;
                        cnt_clear <= 1'b1;
                        busy      <= 1'b1;
                        acc       <= '0;
                        win_idx   <= '0;
                        ovf_flag  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    state     <= S_GATE;
                    cnt_clear <= 1'b0;
                    cnt_en    <= 1'b1;
                end
                S_GATE: begin
                    if (counter_full || timer_done) begin
                        state  <= S_CAPTURE;
                        cnt_en <= 1'b0;
                    end
                    if (counter_full) ovf_flag <= 1'b1;
                end
                S_CAPTURE: begin
                    acc     <= acc_next;
                    win_idx <= win_idx + 1'b1;
                    if (last_win) begin
                        state        <= S_DONE;
                        result_valid <= 1'b1;
                        result       <= acc_next;
                        result_avg   <= COUNT_W'(acc_next >> LOG2_NW);
                        overflow     <= ovf_flag;
                    end else begin
                        state     <= S_CLEAR;
                        cnt_clear <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ack) begin
                        state        <= S_IDLE;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt_en    <= 1'b0;
                    cnt_clear <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
